// File: rtl/softmax_ctrl_if.sv
// Handshake bundle for softmax_ctrl: input beat stream, softmax core link, output word stream.
// slave = controller side, master = producer/core/consumer side.
interface softmax_ctrl_if #(
  parameter int N = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_data;
  logic            core_start;
  logic [N*16-1:0] core_x_flat;
  logic [15:0]     core_max;
  logic            core_done;
  logic [N*16-1:0] core_prob_flat;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;
  logic            out_last;

  modport slave (
    input  in_valid, in_data, core_done, core_prob_flat, out_ready,
    output in_ready, core_start, core_x_flat, core_max, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, core_done, core_prob_flat, out_ready,
    input  in_ready, core_start, core_x_flat, core_max, out_valid, out_data, out_last
  );
endinterface

// File: rtl/softmax_ctrl.sv
// Softmax frame controller: buffers N Q8.8 elements with a running max, kicks the core,
// waits (with timeout) for its result and streams the probabilities out one word at a time.
module softmax_ctrl #(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  softmax_ctrl_if.slave     bus,
  output logic              busy,
  output logic              err_timeout
);
  localparam int BEATS = N / 4;
  localparam int WR_W  = $clog2(BEATS);
  localparam int RD_W  = $clog2(N);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t            state;
  logic [WR_W-1:0]   wr;
  logic [RD_W-1:0]   rd;
  logic [RD_W-1:0]   rd_nxt;
  logic [15:0]       cnt;
  logic [N*16-1:0]   x_buf;
  logic [N*16-1:0]   p_buf;
  logic signed [15:0] beat_max;
  logic signed [15:0] run_max;
  logic              in_ready_r;
  logic              core_start_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic [15:0]       out_data_r;
  logic              busy_r;
  logic              accept;
  logic              take_done;

  assign accept    = (state == LOAD) && bus.in_valid;
  assign take_done = (state == WAIT) && bus.core_done;
  assign rd_nxt    = rd + 1'b1;

  always_comb begin
    beat_max = bus.in_data[15:0];
    for (int unsigned l = 1; l < 4; l++) begin
      if ($signed(bus.in_data[l*16 +: 16]) > beat_max) beat_max = bus.in_data[l*16 +: 16];
    end
  end

  // Frame and result buffers carry no reset; their contents are only consumed after being written.
  always_ff @(posedge clk) begin
    if (accept)    x_buf[{wr, 6'd0} +: 64] <= bus.in_data;
    if (take_done) p_buf <= bus.core_prob_flat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      wr           <= '0;
      rd           <= '0;
      cnt          <= '0;
      run_max      <= '0;
      in_ready_r   <= 1'b1;
      core_start_r <= 1'b0;
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= '0;
      busy_r       <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (bus.in_valid) begin
            // Beat 0 seeds the max so all-negative frames never report 0.
            if (wr == '0 || beat_max > run_max) run_max <= beat_max;
            if (wr == WR_W'(BEATS - 1)) begin
              wr           <= '0;
              state        <= START;
              in_ready_r   <= 1'b0;
              busy_r       <= 1'b1;
              core_start_r <= 1'b1;
            end else begin
              wr <= wr + 1'b1;
            end
          end
        end
        START: begin
          core_start_r <= 1'b0;
          cnt          <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (bus.core_done) begin
            state       <= DRAIN;
            rd          <= '0;
            out_valid_r <= 1'b1;
            out_data_r  <= bus.core_prob_flat[15:0];
            out_last_r  <= 1'b0;
            cnt         <= '0;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= LOAD;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (rd == RD_W'(N - 1)) begin
              state       <= LOAD;
              rd          <= '0;
              out_valid_r <= 1'b0;
              out_last_r  <= 1'b0;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              rd         <= rd_nxt;
              out_data_r <= p_buf[{rd_nxt, 4'd0} +: 16];
              out_last_r <= (rd_nxt == RD_W'(N - 1));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.core_start  = core_start_r;
  assign bus.core_x_flat = x_buf;
  assign bus.core_max    = run_max;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_last    = out_last_r;
  assign busy            = busy_r;
endmodule

// File: doc/softmax_ctrl.md
SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 SHALL have parameter N, default 64, elements per softmax frame; multiple of 4, at least 8.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum WAIT-state cycles before abort; range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  input beat valid.
REQ-006 SHALL have port in_ready  output  1  input beat accepted when in_valid&in_ready.
REQ-007 SHALL have port in_data  input  64  four signed Q8.8 lanes; lane0=[15:0] is element 4k, lane3=[63:48] is element 4k+3.
REQ-008 SHALL have port core_start  output  1  one-cycle start pulse to the softmax core.
REQ-009 SHALL have port core_x_flat  output  N*16  buffered frame; element i at [i*16 +: 16].
REQ-010 SHALL have port core_max  output  16  signed Q8.8 frame maximum.
REQ-011 SHALL have port core_done  input  1  core result valid pulse.
REQ-012 SHALL have port core_prob_flat  input  N*16  core result; element i at [i*16 +: 16].
REQ-013 SHALL have port out_valid  output  1  output word valid.
REQ-014 SHALL have port out_ready  input  1  output word consumed when out_valid&out_ready.
REQ-015 SHALL have port out_data  output  16  probability word, element order 0..N-1.
REQ-016 SHALL have port out_last  output  1  high with element N-1 only.
REQ-017 SHALL have port busy  output  1  high in any state other than LOAD.
REQ-018 SHALL have port err_timeout  output  1  sticky core-timeout flag.

Function
REQ-019 SHALL implement FSM states LOAD, START, WAIT, DRAIN; reset state LOAD.
REQ-020 LOAD: in_ready=1; each accepted beat writes 4 elements at write index wr (log2(N/4) bits, from 0); idle cycles (in_valid=0) hold state.
REQ-021 SHALL track a running signed max over all accepted lanes, seeded by the max of beat 0's lanes, never by 0.
REQ-022 On acceptance of beat N/4-1 SHALL go to START next cycle, with wr wrapped to 0 and in_ready=0.
REQ-023 START: core_start=1 for exactly one cycle, then WAIT.
REQ-024 core_x_flat and core_max SHALL stay stable from START until the exit from WAIT.
REQ-025 WAIT: on core_done=1, SHALL capture core_prob_flat into the output buffer on that edge and enter DRAIN; out_valid=1 the next cycle with element 0.
REQ-026 WAIT: SHALL count cycles; if TIMEOUT cycles elapse without core_done, SHALL set err_timeout, discard the frame, and return to LOAD; core_done in the expiry cycle wins (no error).
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 DRAIN: out_valid=1; out_data=buffer[rd]; rd (log2(N) bits) advances only on valid&ready; out_data/out_last SHALL hold under backpressure.
REQ-029 After the transfer of element N-1 SHALL return to LOAD (in_ready=1 next cycle), out_valid=0, rd=0.
REQ-030 in_ready SHALL be 0 in START, WAIT, DRAIN; no input is accepted during processing.
REQ-031 err_timeout SHALL stay set until rst; later frames SHALL proceed normally.

Reset
REQ-032 rst=1 SHALL immediately force LOAD, wr=0, rd=0, counters 0, core_start=0, out_valid=0, out_last=0, out_data=0, busy=0, err_timeout=0, core_max=0.
REQ-033 Reset mid-frame SHALL abandon the frame; buffer contents are don't-care; first frame after release SHALL be processed correctly.

Verification
REQ-034 N=64, 16 back-to-back beats with element i = i*0x0010 -> core_start high exactly in the cycle after beat 16 accepted, core_max=0x03F0, core_x_flat[i]=i*0x0010.
REQ-035 All elements negative (0xF000..0xF03F, max 0xF03F) -> core_max=0xF03F, not 0x0000.
REQ-036 core_done 5 cycles after start, out_ready toggling every cycle -> 64 words in order, none lost or duplicated, out_last only on word 63, in_ready=0 until after word 63.
REQ-037 core_done never asserted, TIMEOUT=255 -> err_timeout=1 after 255 WAIT cycles, return to LOAD, out_valid never 1; next frame completes with err_timeout still 1.
REQ-038 rst pulsed during DRAIN at word 10 -> out_valid=0 and busy=0 asynchronously; following frame streams words 0..63 correctly.
REQ-039 Stray core_done in LOAD and random in_valid gaps -> no state change from the stray pulse; frame assembled in beat order.
